// File: rtl/score_digit_scanner_pkg.sv
// Shared definitions for the score display path: digit geometry, score ceiling,
// converter FSM encoding and the double-dabble nibble correction.
package score_digit_scanner_pkg;

  localparam int NUM_DIGITS      = 4;
  localparam int BCD_W           = 4;
  localparam int MAX_SCORE       = 9999;
  localparam int DEFAULT_SCORE_W = 14;
  localparam int ITERATIONS      = DEFAULT_SCORE_W;
  localparam int IDX_W           = 2;
  localparam int DISP_W          = NUM_DIGITS * BCD_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_t;

  // Add 3 to every nibble that is 5 or more so the following shift carries correctly.
  function automatic logic [DISP_W-1:0] dabble_adjust(input logic [DISP_W-1:0] bcd);
    logic [DISP_W-1:0] res;
    res = bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[d*BCD_W +: BCD_W] >= 4'd5) begin
        res[d*BCD_W +: BCD_W] = bcd[d*BCD_W +: BCD_W] + 4'd3;
      end else begin
        res[d*BCD_W +: BCD_W] = bcd[d*BCD_W +: BCD_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/score_digit_scanner_bcd.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock, SCORE_W steps.
// bcd_out carries the post-step scratch so the final digits can be taken on the done edge.
module bcd_double_dabble
  import score_digit_scanner_pkg::*;
#(
  parameter int SCORE_W = DEFAULT_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin_in,
  output logic               busy,
  output logic               done,
  output logic [DISP_W-1:0]  bcd_out
);

  localparam int ITER_W = $clog2(SCORE_W + 1);

  conv_state_t        state_r;
  logic [SCORE_W-1:0] bin_r;
  logic [DISP_W-1:0]  bcd_r;
  logic [ITER_W-1:0]  iter_r;

  logic [SCORE_W-1:0] sat_in_s;
  logic [DISP_W-1:0]  adj_s;
  logic [DISP_W-1:0]  next_bcd_s;
  logic [SCORE_W-1:0] next_bin_s;
  logic               last_s;

  // Clamp the score and compute one double-dabble step from the current scratch.
  always_comb begin
    sat_in_s   = bin_in;
    adj_s      = dabble_adjust(bcd_r);
    next_bcd_s = {adj_s[DISP_W-2:0], bin_r[SCORE_W-1]};
    next_bin_s = {bin_r[SCORE_W-2:0], 1'b0};
    last_s     = 1'b0;
    if (32'(bin_in) > 32'(MAX_SCORE)) begin
      sat_in_s = SCORE_W'(MAX_SCORE);
    end else begin
      sat_in_s = bin_in;
    end
    if ((state_r == SHIFT) && (iter_r == ITER_W'(SCORE_W - 1))) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Converter FSM: load on start while idle, then shift once per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      bin_r   <= {SCORE_W{1'b0}};
      bcd_r   <= {DISP_W{1'b0}};
      iter_r  <= {ITER_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            bin_r   <= sat_in_s;
            bcd_r   <= {DISP_W{1'b0}};
            iter_r  <= {ITER_W{1'b0}};
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          bin_r <= next_bin_s;
          bcd_r <= next_bcd_s;
          if (last_s) begin
            iter_r  <= {ITER_W{1'b0}};
            state_r <= IDLE;
          end else begin
            iter_r  <= iter_r + ITER_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          iter_r  <= {ITER_W{1'b0}};
        end
      endcase
    end
  end

  assign busy    = (state_r == SHIFT);
  assign done    = last_s;
  assign bcd_out = next_bcd_s;

endmodule

// File: rtl/score_digit_scanner.sv
// Score display front end: converts a loaded score to BCD, holds it, and scans the
// four digits onto a shared nibble bus with active-low anodes and leading-zero blanking.
module score_digit_scanner
  import score_digit_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int SCORE_W     = DEFAULT_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [BCD_W-1:0]   digit_bin,
  output logic [3:0]         an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DISP_W-1:0] disp_r;
  logic [CNT_W-1:0]  scan_cnt_r;
  logic [IDX_W-1:0]  idx_r;

  logic              conv_done_s;
  logic [DISP_W-1:0] conv_bcd_s;
  logic              blank_s;

  bcd_double_dabble #(
    .SCORE_W (SCORE_W)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start   (score_valid),
    .bin_in  (score),
    .busy    (busy),
    .done    (conv_done_s),
    .bcd_out (conv_bcd_s)
  );

  // Displayed digits change only when a conversion completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r <= {DISP_W{1'b0}};
    end else if (conv_done_s) begin
      disp_r <= conv_bcd_s;
    end
  end

  // Free-running refresh divider; each wrap advances to the next digit slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
    end else if (scan_cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
      scan_cnt_r <= {CNT_W{1'b0}};
      idx_r      <= idx_r + IDX_W'(1);
    end else begin
      scan_cnt_r <= scan_cnt_r + CNT_W'(1);
    end
  end

  // A slot is blank when it and every more significant digit are zero; ones never blanks.
  always_comb begin
    blank_s = 1'b0;
    case (idx_r)
      2'd0:    blank_s = 1'b0;
      2'd1:    blank_s = (disp_r[15:4]  == 12'd0);
      2'd2:    blank_s = (disp_r[15:8]  == 8'd0);
      2'd3:    blank_s = (disp_r[15:12] == 4'd0);
      default: blank_s = 1'b0;
    endcase
  end

  // Slot outputs are pure decodes of the held digits and the scan index.
  always_comb begin
    digit_bin = disp_r[idx_r*BCD_W +: BCD_W];
    if (blank_s) begin
      an = 4'b1111;
    end else begin
      an = ~(4'b0001 << idx_r);
    end
  end

endmodule

// File: tb/tb_score_digit_scanner.sv
// Directed bench for score_digit_scanner with a 4-cycle refresh per digit.
module tb_score_digit_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] score = 14'd0;
  logic        score_valid = 1'b0;
  logic        busy;
  logic [3:0]  digit_bin;
  logic [3:0]  an;

  int k = 0;
  int n_checks = 0;
  int n_pass = 0;

  score_digit_scanner #(
    .REFRESH_DIV (4),
    .SCORE_W     (14)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .digit_bin   (digit_bin),
    .an          (an)
  );

  always #5 clk = ~clk;

  // Count clock edges since reset release to know which slot should be lit.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Walk 16 cycles (all four slots) comparing against the hand-computed slot tables.
  task automatic check_slots(input string tag, input logic [15:0] dig, input logic [15:0] anx);
    for (int c = 0; c < 16; c++) begin
      int idx;
      idx = (k / 4) % 4;
      check_value({tag, " digit"}, {28'd0, digit_bin}, {28'd0, dig[idx*4 +: 4]});
      check_value({tag, " an"}, {28'd0, an}, {28'd0, anx[idx*4 +: 4]});
      @(negedge clk);
    end
  endtask

  // Strobe a score, optionally re-strobe during busy cycle inject_at, and check busy timing.
  task automatic load(input string tag, input logic [13:0] v, input int inject_at, input logic [13:0] v2);
    score = v;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      check_value({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (i == inject_at) begin
        score = v2;
        score_valid = 1'b1;
      end
      @(negedge clk);
      score_valid = 1'b0;
    end
    check_value({tag, " busy end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst an", {28'd0, an}, 32'hE);
    check_value("rst digit", {28'd0, digit_bin}, 32'd0);
    check_value("rst busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_slots("zero", 16'h0000, 16'hFFFE);

    load("s1234", 14'd1234, 0, 14'd0);
    check_slots("s1234", 16'h1234, 16'h7BDE);

    load("s7", 14'd7, 0, 14'd0);
    check_slots("s7", 16'h0007, 16'hFFFE);

    load("s1005", 14'd1005, 0, 14'd0);
    check_slots("s1005", 16'h1005, 16'h7BDE);

    load("s12000", 14'd12000, 0, 14'd0);
    check_slots("s12000", 16'h9999, 16'h7BDE);

    load("s42", 14'd42, 5, 14'd99);
    check_slots("s42", 16'h0042, 16'hFFDE);

    score = 14'd5678;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      check_value("s5678 busy", {31'd0, busy}, 32'd1);
      if (i < 7) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_value("abort busy", {31'd0, busy}, 32'd0);
    check_value("abort an", {28'd0, an}, 32'hE);
    check_value("abort digit", {28'd0, digit_bin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    repeat (10) begin
      check_value("abort idle busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    check_slots("abort", 16'h0000, 16'hFFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
